// File: rtl/csr_hpm_unit_pkg.sv
// CSR address map and small helpers shared by the
// hardware performance monitor unit.
package csr_hpm_unit_pkg;

  typedef logic [11:0] csr_addr_t;

  localparam csr_addr_t MCOUNTINHIBIT = 12'h320;
  localparam csr_addr_t MHPMEVENT3    = 12'h323;
  localparam csr_addr_t MHPMCOUNTER3  = 12'hB03;
  localparam csr_addr_t MHPMCOUNTER3H = 12'hB83;
  localparam csr_addr_t HPMCOUNTER3   = 12'hC03;
  localparam csr_addr_t HPMCOUNTER3H  = 12'hC83;

  // Address of counter/event index idx given the index-3 base
  function automatic csr_addr_t csr_at(
    input csr_addr_t base3,
    input int        idx
  );
    return base3 - 12'd3 + csr_addr_t'(idx);
  endfunction

  function automatic logic [4:0] warl_event(
    input logic [31:0] v,
    input int unsigned n
  );
    return (v > n) ? 5'd0 : v[4:0];
  endfunction

endpackage

// File: rtl/csr_hpm_unit_if.sv
// CSR read/write port between the core writeback
// and the performance monitor unit.
interface csr_hpm_unit_if;
  import csr_hpm_unit_pkg::*;

  csr_addr_t   raddr_i;
  logic [31:0] rdata_o;
  logic        rhit_o;
  logic        we_i;
  csr_addr_t   waddr_i;
  logic [31:0] wdata_i;

  modport master (
    output raddr_i, we_i, waddr_i, wdata_i,
    input  rdata_o, rhit_o
  );

  modport slave (
    input  raddr_i, we_i, waddr_i, wdata_i,
    output rdata_o, rhit_o
  );
endinterface

// File: rtl/csr_hpm_unit_hpm_counter.sv
// One counter slice: half-word writes, increment,
// wrap detection and a registered overflow pulse.
module hpm_counter #(
  parameter int CNT_WIDTH = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 inc,
  input  logic                 we_lo,
  input  logic                 we_hi,
  input  logic [31:0]          wdata,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 ovf
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      ovf <= 1'b0;
      // a write to either half suppresses the increment
      if (we_lo) begin
        cnt[31:0] <= wdata;
      end else if (we_hi) begin
        cnt[CNT_WIDTH-1:32] <= wdata[CNT_WIDTH-33:0];
      end else if (inc) begin
        cnt <= cnt + CNT_WIDTH'(1);
        ovf <= &cnt;
      end
    end
  end

endmodule

// File: rtl/csr_hpm_unit.sv
// Machine counters (mcycle, minstret, mhpmcounterN),
// their event selectors and mcountinhibit.
module csr_hpm_unit
  import csr_hpm_unit_pkg::*;
#(
  parameter int NUM_HPM    = 4,
  parameter int CNT_WIDTH  = 64,
  parameter int NUM_EVENTS = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  csr_hpm_unit_if.slave         bus,
  input  logic                  instret_incr_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  output logic [NUM_HPM+2:0]    ovf_o
);

  localparam int NC = NUM_HPM + 3;
  localparam int NS = NUM_HPM + 2;
  localparam logic [NC-1:0] INH_MASK = ~NC'(2);

  logic [NC-1:0]        inh;
  logic [4:0]           evsel [NUM_HPM];
  logic [CNT_WIDTH-1:0] cnt [NS];
  logic [NS-1:0]        inc;
  logic [NS-1:0]        lo_we;
  logic [NS-1:0]        hi_we;
  logic [NS-1:0]        ovf;
  logic [NUM_HPM-1:0]   ev_we;
  logic                 inh_we;
  logic                 wr_ok;
  logic [31:0]          wr_val;
  logic [31:0]          ev_ext;

  // slot s holds counter index 0, 2, 3, 4, ...
  function automatic int slot_idx(input int s);
    return (s == 0) ? 0 : s + 1;
  endfunction

  // bit 0 is "no event" so selector k picks event_i[k-1]
  assign ev_ext = 32'({event_i, 1'b0});

  assign inc[0] = ~inh[0];
  assign inc[1] = instret_incr_i & ~inh[2];

  for (genvar j = 0; j < NUM_HPM; j++) begin : g_inc
    assign inc[j+2] = ev_ext[evsel[j]] & ~inh[j+3];
  end

  always_comb begin
    wr_ok  = 1'b0;
    wr_val = '0;
    inh_we = 1'b0;
    ev_we  = '0;
    lo_we  = '0;
    hi_we  = '0;
    if (bus.we_i) begin
      if (bus.waddr_i == MCOUNTINHIBIT) begin
        inh_we = 1'b1;
        wr_ok  = 1'b1;
        wr_val = 32'(bus.wdata_i[NC-1:0] & INH_MASK);
      end
      for (int j = 0; j < NUM_HPM; j++) begin
        if (bus.waddr_i == csr_at(MHPMEVENT3, j + 3)) begin
          ev_we[j] = 1'b1;
          wr_ok    = 1'b1;
          wr_val   = 32'(warl_event(bus.wdata_i, NUM_EVENTS));
        end
      end
      for (int s = 0; s < NS; s++) begin
        if (bus.waddr_i == csr_at(MHPMCOUNTER3, slot_idx(s))) begin
          lo_we[s] = 1'b1;
          wr_ok    = 1'b1;
          wr_val   = bus.wdata_i;
        end
        if (bus.waddr_i == csr_at(MHPMCOUNTER3H, slot_idx(s))) begin
          hi_we[s] = 1'b1;
          wr_ok    = 1'b1;
          wr_val   = 32'(bus.wdata_i[CNT_WIDTH-33:0]);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      inh <= '0;
      for (int j = 0; j < NUM_HPM; j++) evsel[j] <= '0;
    end else begin
      if (inh_we) inh <= wr_val[NC-1:0];
      for (int j = 0; j < NUM_HPM; j++) begin
        if (ev_we[j]) evsel[j] <= wr_val[4:0];
      end
    end
  end

  for (genvar s = 0; s < NS; s++) begin : g_cnt
    hpm_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .inc   (inc[s]),
      .we_lo (lo_we[s]),
      .we_hi (hi_we[s]),
      .wdata (bus.wdata_i),
      .cnt   (cnt[s]),
      .ovf   (ovf[s])
    );
  end

  assign ovf_o = {ovf[NS-1:1], 1'b0, ovf[0]};

  always_comb begin
    bus.rdata_o = '0;
    bus.rhit_o  = 1'b0;
    if (bus.raddr_i == MCOUNTINHIBIT) begin
      bus.rhit_o  = 1'b1;
      bus.rdata_o = 32'(inh);
    end
    for (int j = 0; j < NUM_HPM; j++) begin
      if (bus.raddr_i == csr_at(MHPMEVENT3, j + 3)) begin
        bus.rhit_o  = 1'b1;
        bus.rdata_o = 32'(evsel[j]);
      end
    end
    for (int s = 0; s < NS; s++) begin
      if (bus.raddr_i == csr_at(MHPMCOUNTER3, slot_idx(s)) ||
          bus.raddr_i == csr_at(HPMCOUNTER3, slot_idx(s))) begin
        bus.rhit_o  = 1'b1;
        bus.rdata_o = cnt[s][31:0];
      end
      if (bus.raddr_i == csr_at(MHPMCOUNTER3H, slot_idx(s)) ||
          bus.raddr_i == csr_at(HPMCOUNTER3H, slot_idx(s))) begin
        bus.rhit_o  = 1'b1;
        bus.rdata_o = 32'(cnt[s][CNT_WIDTH-1:32]);
      end
    end
    // forward the post-edge value of a same-cycle write
    if (wr_ok && bus.waddr_i == bus.raddr_i) bus.rdata_o = wr_val;
  end

endmodule

// File: tb/tb_csr_hpm_unit.sv
// Bench for csr_hpm_unit: directed scenarios plus a
// randomized run against a CSR-level reference model.
module tb_csr_hpm_unit;

  localparam int NH = 4;
  localparam int NE = 8;
  localparam int NC = NH + 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          instret;
  logic [NE-1:0] ev;
  logic [NC-1:0] ovf;

  int errors = 0;
  int checks = 0;

  bit [63:0]   mc [NC];
  bit [NC-1:0] minh;
  int          mev [NH];
  bit [NC-1:0] movf;
  bit [NC-1:0] inh_mask;

  csr_hpm_unit_if bus ();

  csr_hpm_unit #(
    .NUM_HPM    (NH),
    .CNT_WIDTH  (64),
    .NUM_EVENTS (NE)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .bus            (bus.slave),
    .instret_incr_i (instret),
    .event_i        (ev),
    .ovf_o          (ovf)
  );

  always #5 clk = ~clk;

  function automatic void mread(input logic [11:0] a,
                                output bit hit,
                                output bit [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (a == 12'h320) begin
      hit = 1'b1;
      d   = 32'(minh);
    end
    for (int j = 0; j < NH; j++) begin
      if (a == 12'(12'h323 + j)) begin
        hit = 1'b1;
        d   = 32'(mev[j]);
      end
    end
    for (int i = 0; i < NC; i++) begin
      if (i != 1) begin
        if (a == 12'(12'hB00 + i) || a == 12'(12'hC00 + i)) begin
          hit = 1'b1;
          d   = mc[i][31:0];
        end
        if (a == 12'(12'hB80 + i) || a == 12'(12'hC80 + i)) begin
          hit = 1'b1;
          d   = mc[i][63:32];
        end
      end
    end
  endfunction

  function automatic bit writable(input logic [11:0] a);
    bit w;
    w = (a == 12'h320);
    for (int j = 0; j < NH; j++) if (a == 12'(12'h323 + j)) w = 1'b1;
    for (int i = 0; i < NC; i++) begin
      if (i != 1 && (a == 12'(12'hB00 + i) || a == 12'(12'hB80 + i))) w = 1'b1;
    end
    return w;
  endfunction

  // next state of every architectural register for the current inputs
  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < NC; i++) mc[i] = '0;
      for (int j = 0; j < NH; j++) mev[j] = 0;
      minh = '0;
      movf = '0;
    end else begin
      bit [NC-1:0] novf;
      novf = '0;
      for (int i = 0; i < NC; i++) begin
        bit up;
        int e;
        if (i == 1) continue;
        if (i == 0) up = 1'b1;
        else if (i == 2) up = instret;
        else begin
          e  = mev[i-3];
          up = (e != 0) && ev[e-1];
        end
        if (minh[i]) up = 1'b0;
        if (bus.we_i && bus.waddr_i == 12'(12'hB00 + i))
          mc[i][31:0] = bus.wdata_i;
        else if (bus.we_i && bus.waddr_i == 12'(12'hB80 + i))
          mc[i][63:32] = bus.wdata_i;
        else if (up) begin
          if (mc[i] == 64'hFFFF_FFFF_FFFF_FFFF) novf[i] = 1'b1;
          mc[i] = mc[i] + 64'd1;
        end
      end
      movf = novf;
      if (bus.we_i && bus.waddr_i == 12'h320)
        minh = bus.wdata_i[NC-1:0] & inh_mask;
      for (int j = 0; j < NH; j++) begin
        if (bus.we_i && bus.waddr_i == 12'(12'h323 + j))
          mev[j] = (bus.wdata_i > 32'(NE)) ? 0 : int'(bus.wdata_i);
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [11:0] a);
    bus.raddr_i = a;
    #1;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.we_i    = 1'b1;
    bus.waddr_i = a;
    bus.wdata_i = d;
    tick();
    bus.we_i    = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL reset_mcycle0 got %h want 0", bus.rdata_o);
    end
    checks++;
    if (ovf !== '0) begin
      errors++;
      $display("FAIL reset_ovf got %b want 0", ovf);
    end
    tick();
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'd1) begin
      errors++;
      $display("FAIL reset_mcycle1 got %h want 1", bus.rdata_o);
    end
  endtask

  task automatic test_idle();
    do_reset();
    repeat (10) tick();
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'd10) begin
      errors++;
      $display("FAIL idle_mcycle got %h want 10", bus.rdata_o);
    end
    rd(12'hB02);
    checks++;
    if (bus.rdata_o !== 32'd0 || bus.rhit_o !== 1'b1) begin
      errors++;
      $display("FAIL idle_minstret got %h/%b want 0/1", bus.rdata_o, bus.rhit_o);
    end
    checks++;
    if (ovf !== '0) begin
      errors++;
      $display("FAIL idle_ovf got %b want 0", ovf);
    end
  endtask

  task automatic test_events();
    wr(12'h323, 32'd2);
    repeat (5) begin
      ev = 8'b0000_0010;
      tick();
      ev = '0;
      tick();
    end
    wr(12'h324, 32'd40);
    rd(12'hC03);
    checks++;
    if (bus.rdata_o !== 32'd5 || bus.rhit_o !== 1'b1) begin
      errors++;
      $display("FAIL ev_hpm3 got %h want 5", bus.rdata_o);
    end
    rd(12'h324);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL ev_warl got %h want 0", bus.rdata_o);
    end
    rd(12'h323);
    checks++;
    if (bus.rdata_o !== 32'd2) begin
      errors++;
      $display("FAIL ev_sel3 got %h want 2", bus.rdata_o);
    end
  endtask

  task automatic test_wrap();
    wr(12'hB80, 32'hFFFF_FFFF);
    wr(12'hB00, 32'hFFFF_FFFE);
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL wrap_lo0 got %h want fffffffe", bus.rdata_o);
    end
    tick();
    rd(12'hB80);
    checks++;
    if (bus.rdata_o !== 32'hFFFF_FFFF || ovf !== '0) begin
      errors++;
      $display("FAIL wrap_hi1 got %h/%b want ffffffff/0", bus.rdata_o, ovf);
    end
    tick();
    rd(12'hB80);
    checks++;
    if (bus.rdata_o !== 32'd0 || ovf !== 7'b000_0001) begin
      errors++;
      $display("FAIL wrap_zero got %h/%b want 0/0000001", bus.rdata_o, ovf);
    end
    tick();
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'd1 || ovf !== '0) begin
      errors++;
      $display("FAIL wrap_after got %h/%b want 1/0", bus.rdata_o, ovf);
    end
  endtask

  task automatic test_inhibit();
    bit [63:0] c0;
    bit [63:0] c2;
    wr(12'h320, 32'h4);
    c0 = mc[0];
    c2 = mc[2];
    instret = 1'b1;
    repeat (20) tick();
    instret = 1'b0;
    rd(12'hB02);
    checks++;
    if (bus.rdata_o !== c2[31:0]) begin
      errors++;
      $display("FAIL inh_instret got %h want %h", bus.rdata_o, c2[31:0]);
    end
    c0 = c0 + 64'd20;
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== c0[31:0]) begin
      errors++;
      $display("FAIL inh_mcycle got %h want %h", bus.rdata_o, c0[31:0]);
    end
    rd(12'h320);
    checks++;
    if (bus.rdata_o !== 32'h4) begin
      errors++;
      $display("FAIL inh_read got %h want 4", bus.rdata_o);
    end
    bus.we_i    = 1'b1;
    bus.waddr_i = 12'h320;
    bus.wdata_i = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (bus.rdata_o !== 32'h7D) begin
      errors++;
      $display("FAIL inh_mask got %h want 0000007d", bus.rdata_o);
    end
    tick();
    wr(12'h320, 32'h0);
  endtask

  task automatic test_bypass();
    instret     = 1'b1;
    bus.we_i    = 1'b1;
    bus.waddr_i = 12'hB02;
    bus.wdata_i = 32'h100;
    rd(12'hB02);
    checks++;
    if (bus.rdata_o !== 32'h100) begin
      errors++;
      $display("FAIL byp_write got %h want 100", bus.rdata_o);
    end
    tick();
    bus.we_i = 1'b0;
    rd(12'hB02);
    checks++;
    if (bus.rdata_o !== 32'h100) begin
      errors++;
      $display("FAIL byp_next got %h want 100", bus.rdata_o);
    end
    tick();
    instret = 1'b0;
    rd(12'hB02);
    checks++;
    if (bus.rdata_o !== 32'h101) begin
      errors++;
      $display("FAIL byp_inc got %h want 101", bus.rdata_o);
    end
    bus.we_i    = 1'b1;
    bus.waddr_i = 12'h325;
    bus.wdata_i = 32'd40;
    rd(12'h325);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL byp_warl got %h want 0", bus.rdata_o);
    end
    tick();
    bus.we_i    = 1'b1;
    bus.waddr_i = 12'hB82;
    bus.wdata_i = 32'hABCD;
    rd(12'hB82);
    checks++;
    if (bus.rdata_o !== 32'hABCD) begin
      errors++;
      $display("FAIL byp_hi got %h want abcd", bus.rdata_o);
    end
    tick();
    bus.we_i = 1'b0;
  endtask

  task automatic test_unimpl();
    bit [63:0] c0;
    logic [11:0] na [4];
    na[0] = 12'hB07;
    na[1] = 12'hB01;
    na[2] = 12'h327;
    na[3] = 12'hC87;
    foreach (na[k]) begin
      rd(na[k]);
      checks++;
      if (bus.rhit_o !== 1'b0 || bus.rdata_o !== 32'd0) begin
        errors++;
        $display("FAIL unimpl_%h got %h/%b want 0/0", na[k], bus.rdata_o, bus.rhit_o);
      end
    end
    c0 = mc[0] + 64'd1;
    wr(12'hC00, 32'h1234_5678);
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== c0[31:0]) begin
      errors++;
      $display("FAIL shadow_ro got %h want %h", bus.rdata_o, c0[31:0]);
    end
  endtask

  task automatic test_reset_mid();
    wr(12'h320, 32'h8);
    rst         = 1'b1;
    instret     = 1'b1;
    ev          = '1;
    bus.we_i    = 1'b1;
    bus.waddr_i = 12'hB00;
    bus.wdata_i = 32'h55;
    tick();
    rst      = 1'b0;
    instret  = 1'b0;
    ev       = '0;
    bus.we_i = 1'b0;
    rd(12'hB00);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_mcycle got %h want 0", bus.rdata_o);
    end
    rd(12'h320);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_inh got %h want 0", bus.rdata_o);
    end
    rd(12'h323);
    checks++;
    if (bus.rdata_o !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_ev got %h want 0", bus.rdata_o);
    end
  endtask

  task automatic test_random();
    logic [11:0] tbl [$];
    tbl.push_back(12'h320);
    tbl.push_back(12'h000);
    for (int j = 0; j < NH + 1; j++) tbl.push_back(12'(12'h323 + j));
    for (int i = 0; i < NC + 1; i++) begin
      tbl.push_back(12'(12'hB00 + i));
      tbl.push_back(12'(12'hB80 + i));
      tbl.push_back(12'(12'hC00 + i));
      tbl.push_back(12'(12'hC80 + i));
    end
    for (int j = 0; j < NH; j++) wr(12'(12'h323 + j), 32'(j + 1));
    for (int c = 0; c < 500; c++) begin
      bit eh;
      bit byp;
      bit [31:0] ed;
      bus.raddr_i = tbl[$urandom_range(0, tbl.size() - 1)];
      bus.we_i    = ($urandom_range(0, 4) == 0);
      bus.waddr_i = ($urandom_range(0, 2) == 0) ? bus.raddr_i
                  : tbl[$urandom_range(0, tbl.size() - 1)];
      case ($urandom_range(0, 3))
        0: bus.wdata_i = $urandom;
        1: bus.wdata_i = 32'($urandom_range(0, 12));
        2: bus.wdata_i = 32'hFFFF_FFFF;
        default: bus.wdata_i = 32'hFFFF_FFFD;
      endcase
      instret = 1'($urandom_range(0, 1));
      ev      = NE'($urandom);
      #1;
      mread(bus.raddr_i, eh, ed);
      byp = bus.we_i && bus.waddr_i == bus.raddr_i && writable(bus.raddr_i);
      checks++;
      if (ovf !== movf) begin
        errors++;
        $display("FAIL rnd_ovf c=%0d got %b want %b", c, ovf, movf);
      end
      model_step();
      if (byp) mread(bus.raddr_i, eh, ed);
      checks++;
      if (bus.rhit_o !== eh || bus.rdata_o !== ed) begin
        errors++;
        $display("FAIL rnd_read c=%0d addr=%h got %h/%b want %h/%b",
                 c, bus.raddr_i, bus.rdata_o, bus.rhit_o, ed, eh);
      end
      @(posedge clk);
      #1;
    end
    bus.we_i = 1'b0;
  endtask

  initial begin
    inh_mask    = ~NC'(2);
    rst         = 1'b1;
    instret     = 1'b0;
    ev          = '0;
    bus.raddr_i = '0;
    bus.we_i    = 1'b0;
    bus.waddr_i = '0;
    bus.wdata_i = '0;
    minh        = '0;
    movf        = '0;
    for (int i = 0; i < NC; i++) mc[i] = '0;
    for (int j = 0; j < NH; j++) mev[j] = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_idle();
    test_events();
    test_wrap();
    test_inhibit();
    test_bypass();
    test_unimpl();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
